// File: rtl/dino_motion_ctrl.sv
// Vertical jump/fall controller for the dino sprite, advanced once per frame_tick.
// Optional DINO_FASTFALL_EN: holding duck while airborne aborts the rise and falls faster.
module dino_motion_ctrl #(
  parameter int Y_W        = 10,
  parameter int GROUND_Y   = 380,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL_V = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic [1:0]     gamestate,
  input  logic           jump_btn,
  input  logic           duck_btn,
  output logic [Y_W-1:0] dino_y,
  output logic           is_on_ground,
  output logic           is_lying,
  output logic           jump_start
);

  typedef enum logic [1:0] {
    GROUND  = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10
  } state_t;

  localparam logic [Y_W-1:0] GND_Y  = Y_W'(GROUND_Y);
  localparam logic [Y_W-1:0] JMP_V  = Y_W'(JUMP_V);
  localparam logic [Y_W-1:0] GRAV_V = Y_W'(GRAVITY);
  localparam logic [Y_W-1:0] MAX_V  = Y_W'(MAX_FALL_V);
  localparam logic [Y_W:0]   INC1   = (Y_W+1)'(GRAVITY);
  localparam logic [Y_W:0]   INC3   = (Y_W+1)'(3 * GRAVITY);

  state_t         state;
  logic [Y_W-1:0] vel;
  logic           jump_prev;
  logic           jump_pend;

  logic           running;
  logic           dead;
  logic           jump_edge;
  logic           jump_req;
  logic           fast;
  logic [Y_W:0]   nv_sum;
  logic [Y_W-1:0] nv;
  logic [Y_W:0]   land_sum;

  assign running   = (gamestate == 2'b01);
  assign dead      = (gamestate == 2'b10);
  assign jump_edge = jump_btn & ~jump_prev;
  // an edge on the tick clk itself still launches on that tick
  assign jump_req  = jump_pend | jump_edge;

`ifdef DINO_FASTFALL_EN
  assign fast = duck_btn;
`else
  assign fast = 1'b0;
`endif

  assign nv_sum   = {1'b0, vel} + (fast ? INC3 : INC1);
  assign nv       = (nv_sum > {1'b0, MAX_V}) ? MAX_V
                                             : nv_sum[Y_W-1:0];
  assign land_sum = {1'b0, dino_y} + {1'b0, nv};

  always_ff @(posedge clk) begin
    if (rst || !(running || dead)) begin
      state        <= GROUND;
      dino_y       <= GND_Y;
      vel          <= '0;
      is_on_ground <= 1'b1;
      is_lying     <= 1'b0;
      jump_start   <= 1'b0;
      jump_pend    <= 1'b0;
      jump_prev    <= 1'b0;
    end else begin
      jump_prev    <= jump_btn;
      jump_start   <= 1'b0;
      is_on_ground <= (state == GROUND);
      is_lying     <= running & duck_btn
                      & (state == GROUND);

      // requests never outlive the tick that follows them
      if (frame_tick)
        jump_pend <= 1'b0;
      else if (jump_edge)
        jump_pend <= 1'b1;

      if (frame_tick && running) begin
        unique case (state)
          GROUND: begin
            if (jump_req) begin
              state      <= RISING;
              vel        <= JMP_V;
              jump_start <= 1'b1;
            end
          end
          RISING: begin
            if (fast) begin
              vel   <= '0;
              state <= FALLING;
            end else begin
              dino_y <= dino_y - vel;
              if (vel <= GRAV_V) begin
                vel   <= '0;
                state <= FALLING;
              end else begin
                vel <= vel - GRAV_V;
              end
            end
          end
          FALLING: begin
            if (land_sum >= {1'b0, GND_Y}) begin
              dino_y <= GND_Y;
              vel    <= '0;
              state  <= GROUND;
            end else begin
              dino_y <= land_sum[Y_W-1:0];
              vel    <= nv;
            end
          end
          default: begin
            state <= GROUND;
            vel   <= '0;
          end
        endcase
      end
    end
  end

endmodule
